repl_policy_array: RTL and testbench
====================================

REPL_POLICY_ARRAY -- requirements
Module: repl_policy_array

Interface
REQ-001 SHALL provide parameter s_index, default 3: set index width; num_sets = 2**s_index.
REQ-002 SHALL provide parameter s_assoc, default 8: ways per set; power of two, >= 2.
REQ-003 SHALL provide parameter s_width, default $clog2(s_assoc): way number width.
REQ-004 SHALL provide parameter MODE, default 0: 0 = tree PLRU, 1 = per-set round-robin (FIFO).
REQ-005 SHALL provide clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide read  input  1  victim lookup strobe for rd_index.
REQ-008 SHALL provide rd_index  input  s_index  set being looked up.
REQ-009 SHALL provide way_valid  input  s_assoc  valid bits of set rd_index, sampled with read.
REQ-010 SHALL provide update  input  1  access/fill commit strobe for up_index.
REQ-011 SHALL provide fill  input  1  qualifies update as a line fill (vs hit).
REQ-012 SHALL provide up_index  input  s_index  set being updated.
REQ-013 SHALL provide way_hit  input  s_assoc  one-hot accessed way.
REQ-014 SHALL provide victim  output  s_width  registered victim way.
REQ-015 SHALL provide victim_valid  output  1  high the cycle after an accepted read.
REQ-016 SHALL provide upd_err  output  1  registered one-cycle pulse on an illegal update.

Function
REQ-017 SHALL hold per set s_assoc-1 tree bits (MODE 0) or an s_width pointer (MODE 1).
REQ-018 Tree: heap-indexed nodes 1..s_assoc-1, children of n are 2n and 2n+1; bit 0 = victim in lower-numbered half.
REQ-019 MODE 0 update (hit or fill) SHALL set every node on way w's path to point away from w (w in lower half -> 1, else 0); off-path nodes unchanged.
REQ-020 MODE 1 update SHALL advance pointer by 1 modulo s_assoc only when fill=1; hits leave state unchanged.
REQ-021 Victim SHALL be the lowest-numbered way with way_valid=0 if any exists; otherwise the policy victim (tree walk from node 1, or pointer).
REQ-022 read SHALL register victim and assert victim_valid exactly 1 cycle later; with read=0 victim holds and victim_valid=0.
REQ-023 update with way_hit not one-hot (zero or multiple bits) SHALL change no state and pulse upd_err next cycle.
REQ-024 read and update in same cycle, same index: victim SHALL reflect post-update state (write-first bypass).
REQ-025 read and update in same cycle, different index: both SHALL complete independently in that cycle.
REQ-026 Index wrap: up_index/rd_index = num_sets-1 SHALL address the last set; no aliasing onto set 0.
REQ-027 Consecutive updates to one set on back-to-back cycles SHALL each apply cumulatively, no stall.
REQ-028 No handshake backpressure: every read and legal update SHALL be accepted in its cycle.

Reset
REQ-029 rst=1 at a clock edge SHALL clear all tree bits and pointers to 0, victim to 0, victim_valid and upd_err to 0.
REQ-030 rst SHALL dominate read and update in the same cycle; the coincident update is discarded.
REQ-031 After reset, a full-valid read of any set SHALL return victim 0.

Verification
REQ-032 MODE 0, s_assoc=4: rst; update set 2 way_hit=0001; read set 2, way_valid=1111 -> victim=2, victim_valid=1 next cycle.
REQ-033 MODE 0, s_assoc=4: after REQ-032, update set 2 way_hit=0100 then read set 2 -> victim=1; read set 3 -> victim=0.
REQ-034 Any mode: read set 5 with way_valid=11110111 -> victim=3 regardless of policy state.
REQ-035 MODE 1, s_assoc=8: three fills to set 7 plus two hits -> read set 7 returns victim=3; set 0 returns 0.
REQ-036 way_hit=0011 with update=1 -> upd_err=1 next cycle, subsequent read returns the pre-update victim.
REQ-037 Same-cycle read+update set 1 way_hit=0001 (MODE 0, s_assoc=4, from reset) -> victim=2; rst asserted mid-sequence -> all sets return 0.

Source files
------------

// File: rtl/repl_policy_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : repl_policy_array                                               |
// | Brief  : Per-set cache replacement state, tree PLRU or round-robin FIFO  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module repl_policy_array #(
    parameter int s_index = 3,
    parameter int s_assoc = 8,
    parameter int s_width = $clog2(s_assoc),
    parameter int MODE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic [s_index-1:0] rd_index,
    input  logic [s_assoc-1:0] way_valid,
    input  logic               update,
    input  logic               fill,
    input  logic [s_index-1:0] up_index,
    input  logic [s_assoc-1:0] way_hit,
    output logic [s_width-1:0] victim,
    output logic               victim_valid,
    output logic               upd_err
);
    localparam int c_NUM_SETS = 2**s_index;

    logic               w_hit_onehot;
    logic               w_upd_ok;
    logic               w_bypass;
    logic               w_any_invalid;
    logic [s_width-1:0] w_free_way;
    logic [s_width-1:0] w_policy_way;
    logic [s_width-1:0] r_victim;
    logic               r_victim_valid;
    logic               r_upd_err;

    assign w_hit_onehot = ($countones(way_hit) == 1);
    assign w_upd_ok     = update && w_hit_onehot;
    // Read of the set being updated this cycle sees the updated state
    assign w_bypass     = w_upd_ok && (up_index == rd_index);

    always_comb begin
        w_any_invalid = 1'b0;
        w_free_way    = '0;
        for (int i = s_assoc - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                w_any_invalid = 1'b1;
                w_free_way    = s_width'(i);
            end
        end
    end

    generate
        if (MODE == 0) begin : g_plru
            logic [s_assoc-1:1] r_tree [c_NUM_SETS];
            logic [s_assoc-1:1] w_tree_next;
            logic [s_assoc-1:1] w_tree_rd;
            logic [s_width-1:0] w_hit_way;
            logic               w_unused_fill;

            // Hits and fills touch the tree identically
            assign w_unused_fill = fill;

            always_comb begin : p_tree_next
                logic [s_width-1:0] w_node;
                logic [s_width-1:0] w_path;
                w_hit_way = '0;
                for (int i = 0; i < s_assoc; i++) begin
                    if (way_hit[i]) w_hit_way = s_width'(i);
                end
                w_tree_next = r_tree[up_index];
                w_node      = s_width'(1);
                w_path      = w_hit_way;
                for (int l = 0; l < s_width; l++) begin
                    w_tree_next[w_node] = ~w_path[s_width-1];
                    w_node = (w_node << 1) | s_width'(w_path[s_width-1]);
                    w_path = w_path << 1;
                end
            end

            always_comb begin : p_tree_walk
                logic [s_width-1:0] w_node;
                logic               w_dir;
                w_tree_rd    = w_bypass ? w_tree_next : r_tree[rd_index];
                w_node       = s_width'(1);
                w_dir        = 1'b0;
                w_policy_way = '0;
                for (int l = 0; l < s_width; l++) begin
                    w_dir        = w_tree_rd[w_node];
                    w_policy_way = (w_policy_way << 1) | s_width'(w_dir);
                    w_node       = (w_node << 1) | s_width'(w_dir);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < c_NUM_SETS; s++) r_tree[s] <= '0;
                end else if (w_upd_ok) begin
                    r_tree[up_index] <= w_tree_next;
                end
            end
        end else begin : g_fifo
            logic [s_width-1:0] r_ptr [c_NUM_SETS];
            logic [s_width-1:0] w_ptr_next;

            assign w_ptr_next   = fill ? r_ptr[up_index] + s_width'(1) : r_ptr[up_index];
            assign w_policy_way = w_bypass ? w_ptr_next : r_ptr[rd_index];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < c_NUM_SETS; s++) r_ptr[s] <= '0;
                end else if (w_upd_ok) begin
                    r_ptr[up_index] <= w_ptr_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_victim       <= '0;
            r_victim_valid <= 1'b0;
            r_upd_err      <= 1'b0;
        end else begin
            r_victim_valid <= read;
            r_upd_err      <= update && !w_hit_onehot;
            if (read) r_victim <= w_any_invalid ? w_free_way : w_policy_way;
        end
    end

    assign victim       = r_victim;
    assign victim_valid = r_victim_valid;
    assign upd_err      = r_upd_err;

endmodule
`default_nettype wire

// File: tb/tb_repl_policy_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_repl_policy_array                                            |
// | Brief  : Directed bench: PLRU instance (4-way) and FIFO instance (8-way)  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_repl_policy_array;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       p_read, p_update, p_fill;
    logic [2:0] p_rd_index, p_up_index;
    logic [3:0] p_way_valid, p_way_hit;
    logic [1:0] p_victim;
    logic       p_vv, p_err;
    logic       f_read, f_update, f_fill;
    logic [2:0] f_rd_index, f_up_index;
    logic [7:0] f_way_valid, f_way_hit;
    logic [2:0] f_victim;
    logic       f_vv, f_err;

    int vectors     = 0;
    int miscompares = 0;

    repl_policy_array #(.s_index(3), .s_assoc(4), .MODE(0)) dut_p (
        .clk(clk), .rst(rst), .read(p_read), .rd_index(p_rd_index), .way_valid(p_way_valid),
        .update(p_update), .fill(p_fill), .up_index(p_up_index), .way_hit(p_way_hit),
        .victim(p_victim), .victim_valid(p_vv), .upd_err(p_err));

    repl_policy_array #(.s_index(3), .s_assoc(8), .MODE(1)) dut_f (
        .clk(clk), .rst(rst), .read(f_read), .rd_index(f_rd_index), .way_valid(f_way_valid),
        .update(f_update), .fill(f_fill), .up_index(f_up_index), .way_hit(f_way_hit),
        .victim(f_victim), .victim_valid(f_vv), .upd_err(f_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p_upd(input logic [2:0] idx, input logic [3:0] hit);
        p_update = 1'b1; p_up_index = idx; p_way_hit = hit; p_fill = 1'b0;
        tick();
        p_update = 1'b0;
    endtask

    task automatic p_rd(input logic [2:0] idx, input logic [3:0] vld);
        p_read = 1'b1; p_rd_index = idx; p_way_valid = vld;
        tick();
        p_read = 1'b0;
    endtask

    task automatic f_upd(input logic [2:0] idx, input logic [7:0] hit, input logic fl);
        f_update = 1'b1; f_up_index = idx; f_way_hit = hit; f_fill = fl;
        tick();
        f_update = 1'b0;
    endtask

    task automatic f_rd(input logic [2:0] idx, input logic [7:0] vld);
        f_read = 1'b1; f_rd_index = idx; f_way_valid = vld;
        tick();
        f_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++; if (p_victim !== 2'd0) begin miscompares++; $display("FAIL reset_p_victim got=%0d want=0", p_victim); end
        vectors++; if (p_vv !== 1'b0) begin miscompares++; $display("FAIL reset_p_vv got=%b want=0", p_vv); end
        vectors++; if (p_err !== 1'b0) begin miscompares++; $display("FAIL reset_p_err got=%b want=0", p_err); end
        vectors++; if (f_victim !== 3'd0 || f_vv !== 1'b0 || f_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_f got victim=%0d vv=%b err=%b want 0/0/0", f_victim, f_vv, f_err);
        end
        for (int s = 0; s < 8; s++) begin
            p_read = 1'b1; p_rd_index = 3'(s); p_way_valid = 4'hF;
            f_read = 1'b1; f_rd_index = 3'(s); f_way_valid = 8'hFF;
            tick();
            vectors++; if (p_victim !== 2'd0 || p_vv !== 1'b1) begin
                miscompares++; $display("FAIL reset_read_p set=%0d got victim=%0d vv=%b want 0/1", s, p_victim, p_vv);
            end
            vectors++; if (f_victim !== 3'd0 || f_vv !== 1'b1) begin
                miscompares++; $display("FAIL reset_read_f set=%0d got victim=%0d vv=%b want 0/1", s, f_victim, f_vv);
            end
        end
        p_read = 1'b0; f_read = 1'b0;
    endtask

    task automatic test_plru();
        p_upd(3'd2, 4'b0001);
        p_rd(3'd2, 4'b1111);
        vectors++; if (p_victim !== 2'd2 || p_vv !== 1'b1) begin
            miscompares++; $display("FAIL plru_way0 got victim=%0d vv=%b want 2/1", p_victim, p_vv);
        end
        tick();
        vectors++; if (p_victim !== 2'd2 || p_vv !== 1'b0) begin
            miscompares++; $display("FAIL plru_hold got victim=%0d vv=%b want 2/0", p_victim, p_vv);
        end
        p_upd(3'd2, 4'b0100);
        p_rd(3'd2, 4'b1111);
        vectors++; if (p_victim !== 2'd1) begin miscompares++; $display("FAIL plru_way2 got=%0d want=1", p_victim); end
        p_rd(3'd3, 4'b1111);
        vectors++; if (p_victim !== 2'd0) begin miscompares++; $display("FAIL plru_set3 got=%0d want=0", p_victim); end
    endtask

    task automatic test_free_way();
        f_rd(3'd5, 8'b11110111);
        vectors++; if (f_victim !== 3'd3) begin miscompares++; $display("FAIL free_f got=%0d want=3", f_victim); end
        p_rd(3'd2, 4'b1011);
        vectors++; if (p_victim !== 2'd2) begin miscompares++; $display("FAIL free_p_1011 got=%0d want=2", p_victim); end
        p_rd(3'd2, 4'b0110);
        vectors++; if (p_victim !== 2'd0) begin miscompares++; $display("FAIL free_p_0110 got=%0d want=0", p_victim); end
    endtask

    task automatic test_fifo();
        f_upd(3'd7, 8'h01, 1'b1);
        f_upd(3'd7, 8'h02, 1'b1);
        f_upd(3'd7, 8'h04, 1'b0);
        f_upd(3'd7, 8'h08, 1'b1);
        f_upd(3'd7, 8'h10, 1'b0);
        f_rd(3'd7, 8'hFF);
        vectors++; if (f_victim !== 3'd3) begin miscompares++; $display("FAIL fifo_set7 got=%0d want=3", f_victim); end
        f_rd(3'd0, 8'hFF);
        vectors++; if (f_victim !== 3'd0) begin miscompares++; $display("FAIL fifo_set0 got=%0d want=0", f_victim); end
        for (int k = 0; k < 5; k++) f_upd(3'd7, 8'h80, 1'b1);
        f_rd(3'd7, 8'hFF);
        vectors++; if (f_victim !== 3'd0) begin miscompares++; $display("FAIL fifo_wrap got=%0d want=0", f_victim); end
        f_upd(3'd7, 8'h40, 1'b1);
        f_rd(3'd7, 8'hFF);
        vectors++; if (f_victim !== 3'd1) begin miscompares++; $display("FAIL fifo_after_wrap got=%0d want=1", f_victim); end
    endtask

    task automatic test_upd_err();
        p_upd(3'd2, 4'b0011);
        vectors++; if (p_err !== 1'b1) begin miscompares++; $display("FAIL err_multi got=%b want=1", p_err); end
        tick();
        vectors++; if (p_err !== 1'b0) begin miscompares++; $display("FAIL err_pulse got=%b want=0", p_err); end
        p_rd(3'd2, 4'b1111);
        vectors++; if (p_victim !== 2'd1) begin miscompares++; $display("FAIL err_state_p got=%0d want=1", p_victim); end
        p_upd(3'd2, 4'b0000);
        vectors++; if (p_err !== 1'b1) begin miscompares++; $display("FAIL err_zero got=%b want=1", p_err); end
        f_upd(3'd7, 8'h00, 1'b1);
        vectors++; if (f_err !== 1'b1) begin miscompares++; $display("FAIL err_f got=%b want=1", f_err); end
        f_rd(3'd7, 8'hFF);
        vectors++; if (f_victim !== 3'd1) begin miscompares++; $display("FAIL err_state_f got=%0d want=1", f_victim); end
    endtask

    task automatic test_bypass();
        p_read = 1'b1; p_rd_index = 3'd1; p_way_valid = 4'hF;
        p_update = 1'b1; p_up_index = 3'd1; p_way_hit = 4'b0001;
        tick();
        vectors++; if (p_victim !== 2'd2) begin miscompares++; $display("FAIL bypass_same got=%0d want=2", p_victim); end
        p_rd_index = 3'd3; p_up_index = 3'd4;
        tick();
        p_read = 1'b0; p_update = 1'b0;
        vectors++; if (p_victim !== 2'd0) begin miscompares++; $display("FAIL bypass_diff_rd got=%0d want=0", p_victim); end
        p_rd(3'd4, 4'hF);
        vectors++; if (p_victim !== 2'd2) begin miscompares++; $display("FAIL bypass_diff_up got=%0d want=2", p_victim); end
        f_read = 1'b1; f_rd_index = 3'd6; f_way_valid = 8'hFF;
        f_update = 1'b1; f_up_index = 3'd6; f_way_hit = 8'h01; f_fill = 1'b1;
        tick();
        f_read = 1'b0; f_update = 1'b0;
        vectors++; if (f_victim !== 3'd1) begin miscompares++; $display("FAIL bypass_fifo got=%0d want=1", f_victim); end
    endtask

    task automatic test_index_wrap();
        p_upd(3'd7, 4'b0001);
        p_rd(3'd7, 4'hF);
        vectors++; if (p_victim !== 2'd2) begin miscompares++; $display("FAIL wrap_set7 got=%0d want=2", p_victim); end
        p_rd(3'd0, 4'hF);
        vectors++; if (p_victim !== 2'd0) begin miscompares++; $display("FAIL wrap_set0 got=%0d want=0", p_victim); end
    endtask

    task automatic test_back_to_back();
        p_upd(3'd5, 4'b0001);
        p_upd(3'd5, 4'b0100);
        p_rd(3'd5, 4'hF);
        vectors++; if (p_victim !== 2'd1) begin miscompares++; $display("FAIL b2b_set5 got=%0d want=1", p_victim); end
        p_upd(3'd5, 4'b0010);
        p_upd(3'd5, 4'b1000);
        p_rd(3'd5, 4'hF);
        vectors++; if (p_victim !== 2'd0) begin miscompares++; $display("FAIL b2b_set5_b got=%0d want=0", p_victim); end
    endtask

    task automatic test_reset_mid();
        p_upd(3'd6, 4'b0001);
        p_rd(3'd6, 4'hF);
        vectors++; if (p_victim !== 2'd2) begin miscompares++; $display("FAIL mid_pre got=%0d want=2", p_victim); end
        rst = 1'b1;
        p_read = 1'b1; p_rd_index = 3'd6; p_way_valid = 4'hF;
        p_update = 1'b1; p_up_index = 3'd6; p_way_hit = 4'b0100;
        tick();
        rst = 1'b0; p_read = 1'b0; p_update = 1'b0;
        vectors++; if (p_victim !== 2'd0 || p_vv !== 1'b0 || p_err !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst got victim=%0d vv=%b err=%b want 0/0/0", p_victim, p_vv, p_err);
        end
        for (int s = 0; s < 8; s++) begin
            p_read = 1'b1; p_rd_index = 3'(s); p_way_valid = 4'hF;
            f_read = 1'b1; f_rd_index = 3'(s); f_way_valid = 8'hFF;
            tick();
            vectors++; if (p_victim !== 2'd0 || f_victim !== 3'd0) begin
                miscompares++; $display("FAIL mid_read set=%0d got p=%0d f=%0d want 0/0", s, p_victim, f_victim);
            end
        end
        p_read = 1'b0; f_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        p_read = 1'b0; p_update = 1'b0; p_fill = 1'b0;
        p_rd_index = '0; p_up_index = '0; p_way_valid = '1; p_way_hit = '0;
        f_read = 1'b0; f_update = 1'b0; f_fill = 1'b0;
        f_rd_index = '0; f_up_index = '0; f_way_valid = '1; f_way_hit = '0;
        test_reset();
        test_plru();
        test_free_way();
        test_fifo();
        test_upd_err();
        test_bypass();
        test_index_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
